// File: rtl/vedic_4x4.sv
// Registered 4x4 unsigned Urdhva Tiryagbhyam multiplier: input reg -> 2x2 partials -> ripple combine -> output reg.
// Latency 2 edges (3 with VEDIC_PIPE_STAGE_EN, which registers q0..q3); ena=0 freezes every register.

module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic cross_hi, cross_lo, vert_hi, c1;

  assign cross_hi = a[1] & b[0];
  assign cross_lo = a[0] & b[1];
  assign vert_hi  = a[1] & b[1];
  assign c1       = cross_hi & cross_lo;

  assign p[0] = a[0] & b[0];
  assign p[1] = cross_hi ^ cross_lo;
  assign p[2] = vert_hi ^ c1;
  assign p[3] = vert_hi & c1;
endmodule

module ripple_add #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         co
);
  logic [W:0] c;

  always_comb begin
    c   = '0;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[W];
  end
endmodule

module vedic_4x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [3:0] a_r, b_r;
  logic [3:0] q0, q1, q2, q3;
  logic [3:0] q0_u, q1_u, q2_u, q3_u;
  logic [7:0] p_r, p;
  logic       unused_ok;

  assign uio_out   = 8'h00;
  assign uio_oe    = 8'h00;
  assign unused_ok = &{1'b0, uio_in};

  vedic_2x2 u_q0 (.a(a_r[1:0]), .b(b_r[1:0]), .p(q0));
  vedic_2x2 u_q1 (.a(a_r[3:2]), .b(b_r[1:0]), .p(q1));
  vedic_2x2 u_q2 (.a(a_r[1:0]), .b(b_r[3:2]), .p(q2));
  vedic_2x2 u_q3 (.a(a_r[3:2]), .b(b_r[3:2]), .p(q3));

`ifdef VEDIC_PIPE_STAGE_EN
  logic [15:0] q_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
    end else if (ena) begin
      q_r <= {q3, q2, q1, q0};
    end
  end

  assign {q3_u, q2_u, q1_u, q0_u} = q_r;
`else
  assign {q3_u, q2_u, q1_u, q0_u} = {q3, q2, q1, q0};
`endif

  // Bits [1:0] come straight from q0; everything above is a 6-bit sum at weight 4.
  logic [3:0] mid_sum;
  logic       mid_co;
  logic [5:0] hi_a, hi_b;
  logic       unused_co0, unused_co1;

  ripple_add #(.W(4)) u_mid (.a(q1_u), .b(q2_u), .sum(mid_sum), .co(mid_co));

  ripple_add #(.W(6)) u_hi0 (
    .a  ({4'b0000, q0_u[3:2]}),
    .b  ({1'b0, mid_co, mid_sum}),
    .sum(hi_a),
    .co (unused_co0)
  );

  ripple_add #(.W(6)) u_hi1 (
    .a  (hi_a),
    .b  ({q3_u, 2'b00}),
    .sum(hi_b),
    .co (unused_co1)
  );

  assign p = {hi_b, q0_u[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      p_r <= '0;
    end else if (ena) begin
      a_r <= ui_in[7:4];
      b_r <= ui_in[3:0];
      p_r <= p;
    end
  end

  assign uo_out = p_r;
endmodule

// File: tb/tb_vedic_4x4.sv
// Self-checking bench for vedic_4x4: delay-line product model checked every cycle plus literal spot checks.
module tb_vedic_4x4;
`ifdef VEDIC_PIPE_STAGE_EN
  localparam int L = 3;
`else
  localparam int L = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'hFF;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;
  int hist[$];

  vedic_4x4 dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in),
    .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  // Model: output is the product accepted L enabled edges ago; reset refills with zeros.
  always @(posedge clk) begin
    if (rst) begin
      hist = {};
      for (int i = 0; i < L; i++) hist.push_back(0);
    end else if (ena) begin
      hist.push_back(int'(ui_in[7:4]) * int'(ui_in[3:0]));
      void'(hist.pop_front());
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      vectors++;
      if (int'(uo_out) != hist[0] || uio_out != 8'h00 || uio_oe != 8'h00) begin
        miscompares++;
        $display("FAIL model t=%0t uo_out=%0d expected=%0d uio_out=%h uio_oe=%h", $time, uo_out, hist[0], uio_out, uio_oe);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Inputs change at negedge; model and DUT sample at the following posedge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  int got[8];
  int exp_stream[4] = '{1, 6, 49, 15};
  logic [7:0] pairs[4] = '{8'h11, 8'h23, 8'h77, 8'hF1};
  logic [7:0] basic_in[4] = '{8'h32, 8'h54, 8'hFF, 8'h90};
  int basic_exp[4] = '{6, 20, 225, 0};

  initial begin
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("reset_hold", int'(uo_out), 0);
    end
    rst = 1'b0;
    step(L - 1);
    check("post_reset_early", int'(uo_out), 0);
    step(1);
    check("post_reset_first", int'(uo_out), 225);

    for (int i = 0; i < 4; i++) begin
      ui_in = basic_in[i];
      step(5);
      check("basic", int'(uo_out), basic_exp[i]);
    end

    for (int k = 0; k < 8; k++) begin
      if (k < 4) ui_in = pairs[k];
      step(1);
      got[k] = int'(uo_out);
    end
    for (int i = 0; i < 4; i++) check("stream", got[i + L - 1], exp_stream[i]);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        ui_in = 8'((a << 4) | b);
        uio_in = 8'($urandom);
        step(1);
      end
    step(L);

    ui_in = 8'h54;
    step(5);
    check("hold_pre", int'(uo_out), 20);
    ena = 1'b0;
    ui_in = 8'hFF;
    step(5);
    check("hold_frozen", int'(uo_out), 20);
    ena = 1'b1;
    step(L);
    check("hold_release", int'(uo_out), 225);

    step(2);
    rst = 1'b1;
    step(1);
    check("mid_reset", int'(uo_out), 0);
    rst = 1'b0;
    step(L);
    check("mid_reset_recover", int'(uo_out), 225);

    for (int i = 0; i < 400; i++) begin
      ui_in = 8'($urandom);
      uio_in = 8'($urandom);
      ena = ($urandom_range(0, 9) < 8);
      rst = ($urandom_range(0, 99) < 3);
      step(1);
    end
    rst = 1'b0;
    ena = 1'b1;
    step(L + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vedic_4x4.md
# vedic_4x4

Registered 4-bit × 4-bit unsigned multiplier built from the Vedic "Urdhva Tiryagbhyam" (vertical-and-crosswise) structure. It is the top-level user block in the standard 8-in / 8-out / 8-bidir tile wrapper. Operands arrive packed on the dedicated input bus, and the 8-bit product is driven on the dedicated output bus. The bidirectional pins are unused.

## Interface
Parameters: none (configuration is by macro only; see Configuration).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- ena  input  1  clock enable; when 0, all registers hold their value
- ui_in  input  8  operands: A = ui_in[7:4], B = ui_in[3:0], both unsigned
- uo_out  output  8  registered product A×B, unsigned
- uio_in  input  8  unused; ignored
- uio_out  output  8  tied to 8'h00
- uio_oe  output  8  tied to 8'h00 (all bidir pins are inputs)

## Operation
- Input register: A_r and B_r (4 bits each) capture ui_in when ena=1.
- Product datapath:
  - Split operands: A_r = {Ah,Al}, B_r = {Bh,Bl} (2-bit halves).
  - Four 2×2 Vedic sub-multipliers, each built from AND gates plus two half adders, produce 4-bit results: q0=Al·Bl, q1=Ah·Bl, q2=Al·Bh, q3=Ah·Bh.
  - Combine: P = q0 + ((q1 + q2) << 2) + (q3 << 4).
  - Use explicit ripple adders: 4-bit adder for q1+q2 giving a 5-bit result; 6-bit adders for the remaining terms.
  - P[1:0] = q0[1:0] directly.
- Output register: P_r (8 bits) captures P when ena=1; uo_out = P_r.
- Width rule: the maximum product is 15×15 = 225, which fits in 8 bits. No overflow or truncation.
- Reset:
  - A_r, B_r, P_r and any pipeline registers are cleared to 0.
  - uo_out = 8'h00 while in reset and until the first valid result.
  - rst has priority over ena.
- ena=0: every register holds its value; uo_out is frozen.
- Reset mid-operation: in-flight data is discarded. Output returns 0 on the first edge with rst=1.

## Timing
- Default latency is 2 rising edges.
  - ui_in is sampled at edge N.
  - uo_out shows the product after edge N+1.
- Throughput is one new operand pair per cycle (fully pipelined).
- Counting under ena=0: cycles with ena=0 do not count toward latency.
- After rst deasserts with stable ui_in, uo_out is valid after the 2nd edge (3rd edge with PIPE macro).
- An operand change while a previous result is in flight does not disturb that result.
- The output register changes only on clock edges; it is glitch-free.

## Configuration
- VEDIC_PIPE_STAGE_EN:
  - Defined: adds a register stage holding q0..q3 (16 bits) between the sub-multipliers and the final adder. Latency becomes 3 edges.
  - Undefined: q0..q3 feed the adders combinationally. Latency is 2 edges.
- In both builds:
  - The stage is reset to 0.
  - The stage obeys ena.
  - The arithmetic result is identical.

## Test plan
- Reset: assert rst for 5 cycles with ui_in=8'hFF -> uo_out=0 throughout. After release, the first valid value is 225 after the latency.
- Basic products, each held 5 cycles with ena=1:
  - ui_in={3,2} -> uo_out=6
  - {5,4} -> 20
  - {15,15} -> 225
  - {9,0} -> 0
- Back-to-back streaming: apply {1,1},{2,3},{7,7},{15,1} on consecutive cycles -> uo_out sequence 1,6,49,15, starting exactly at the latency.
- Exhaustive sweep: all 256 A,B pairs -> uo_out = A×B, checked after the latency. Run in both macro builds.
- Enable hold: set ena=0 with uo_out=20, change ui_in to {15,15} -> uo_out stays 20. Set ena=1 -> 225 after the latency.
- Mid-stream reset: pulse rst for 1 cycle while streaming {15,15} -> uo_out=0 on the next edge. Output returns to 225 after the latency once rst deasserts. uio_out and uio_oe stay 0 at all times.
